// File: rtl/mux_sel_pipe_pkg.sv
// Shared decode-stage constants and types for the register-destination select path.
// Holds the select codes and the skid-buffer occupancy encoding.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] RA_IDX = 5'd31;

  typedef enum logic [1:0] {
    SEL_RT = 2'd0,
    SEL_RD = 2'd1,
    SEL_RA = 2'd2
  } sel_code_e;

  // Encoding is {skid_valid, main_valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_e;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
    return sel < num_in;
  endfunction

endpackage

// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle between decode, the select pipe and the ID/EX register.
// sel_err exists only when MUX_SEL_CHECK_EN is defined.
interface mux_sel_pipe_if #(
  parameter int WIDTH     = 5,
  parameter int NUM_IN    = 4,
  parameter int OUT_WIDTH = 32
);

  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    out_valid;
  logic                    out_ready;
`ifdef MUX_SEL_CHECK_EN
  logic                    sel_err;

  modport master (
    output in_bus, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_bus, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
`else
  modport master (
    output in_bus, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_bus, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
`endif

endinterface

// File: rtl/mux_sel_pipe_skid.sv
// Two-entry skid buffer: main register drives the output, skid catches one item
// while downstream stalls so in_ready depends only on local state.
//
// state     | meaning
// ----------+-----------------------------------------------
// BUF_EMPTY | nothing held, output invalid
// BUF_ONE   | main holds the head item, skid empty
// BUF_FULL  | main holds head, skid holds next; upstream stalled
module mux_skid_buf
  import mips_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  buf_state_e    state, state_nxt;
  logic [PW-1:0] main_data, skid_data;
  logic          acc, drn;
  logic          ld_main_in, ld_main_skid, ld_skid;

  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign out_data  = main_data;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (acc) begin
          state_nxt  = BUF_ONE;
          ld_main_in = 1'b1;
        end
      end
      BUF_ONE: begin
        if (acc && drn) begin
          ld_main_in = 1'b1;
        end else if (acc) begin
          state_nxt = BUF_FULL;
          ld_skid   = 1'b1;
        end else if (drn) begin
          state_nxt = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (drn) begin
          state_nxt    = BUF_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= BUF_EMPTY;
    else     state <= state_nxt;
  end

  // main keeps its last value across bubbles; only loads move it
  always_ff @(posedge Clk) begin
    if (Rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (ld_main_in)        main_data <= in_data;
      else if (ld_main_skid) main_data <= skid_data;
      if (ld_skid)           skid_data <= in_data;
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-input register-destination select, zero-extended, behind a 2-entry skid buffer.
// Define MUX_SEL_CHECK_EN to carry an out-of-range-select flag out on sel_err.
module mux_sel_pipe
  import mips_pkg::*;
#(
  parameter int WIDTH     = REG_W,
  parameter int NUM_IN    = 4,
  parameter int OUT_WIDTH = DATA_W
) (
  input  logic          Clk,
  input  logic          Rst,
  mux_sel_pipe_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_IN);
`ifdef MUX_SEL_CHECK_EN
  localparam int PW = OUT_WIDTH + 1;
`else
  localparam int PW = OUT_WIDTH;
`endif

  logic [WIDTH-1:0] sel_val;
  logic [PW-1:0]    pay_in, pay_out;

  // an unmatched select (only possible for non-power-of-2 NUM_IN) leaves zero
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SEL_W'(i)) sel_val = bus.in_bus[i*WIDTH +: WIDTH];
    end
  end

`ifdef MUX_SEL_CHECK_EN
  assign pay_in = {~sel_in_range(32'(bus.sel), NUM_IN), OUT_WIDTH'(sel_val)};
`else
  assign pay_in = OUT_WIDTH'(sel_val);
`endif

  mux_skid_buf #(.PW(PW)) u_skid (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_out)
  );

  assign bus.out_data = pay_out[OUT_WIDTH-1:0];
`ifdef MUX_SEL_CHECK_EN
  assign bus.sel_err  = pay_out[OUT_WIDTH] & bus.out_valid;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: directed vector table, out-of-range sequence on a
// 3-input instance, and a random run against a queue model.
module tb_mux_sel_pipe;
  import mips_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 Clk = ~Clk;

  mux_sel_pipe_if #(.WIDTH(5), .NUM_IN(4), .OUT_WIDTH(32)) if4 ();
  mux_sel_pipe_if #(.WIDTH(5), .NUM_IN(3), .OUT_WIDTH(32)) if3 ();

  mux_sel_pipe #(.WIDTH(5), .NUM_IN(4), .OUT_WIDTH(32)) u4 (.Clk(Clk), .Rst(Rst), .bus(if4));
  mux_sel_pipe #(.WIDTH(5), .NUM_IN(3), .OUT_WIDTH(32)) u3 (.Clk(Clk), .Rst(Rst), .bus(if3));

  typedef struct {
    logic        rst;
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic        exp_ir;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic rst, logic iv, logic [1:0] sel, logic ordy,
                              logic ov, logic [31:0] od, logic ir);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sel = sel; v.ordy = ordy;
    v.exp_ov = ov; v.exp_od = od; v.exp_ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] q[$];
  logic [31:0] last_out;
  logic [19:0] rbus;
  logic [1:0]  rsel;
  logic        riv, rordy, acc, drn;
  logic [31:0] ev;

  initial begin
    // inputs 0..3 = 3, 17, 31 ($ra), 9
    if4.in_bus    = {5'd9, RA_IDX, 5'd17, 5'd3};
    if4.sel       = '0;
    if4.in_valid  = 1'b1;
    if4.out_ready = 1'b1;
    if3.in_bus    = {5'd7, 5'd6, 5'd5};
    if3.sel       = '0;
    if3.in_valid  = 1'b0;
    if3.out_ready = 1'b1;

    //               rst   iv    sel     ordy  ov    od       ir
    tbl[0]  = mk(1'b1, 1'b1, SEL_RT, 1'b1, 1'b0, 32'd0,  1'b1);
    tbl[1]  = mk(1'b1, 1'b1, SEL_RT, 1'b1, 1'b0, 32'd0,  1'b1);
    tbl[2]  = mk(1'b0, 1'b1, SEL_RT, 1'b1, 1'b1, 32'd3,  1'b1);
    tbl[3]  = mk(1'b0, 1'b1, SEL_RD, 1'b1, 1'b1, 32'd17, 1'b1);
    tbl[4]  = mk(1'b0, 1'b1, SEL_RA, 1'b1, 1'b1, 32'd31, 1'b1);
    tbl[5]  = mk(1'b0, 1'b1, 2'd3,   1'b1, 1'b1, 32'd9,  1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 2'd0,   1'b1, 1'b0, 32'd9,  1'b1);
    tbl[7]  = mk(1'b0, 1'b1, SEL_RD, 1'b0, 1'b1, 32'd17, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, SEL_RA, 1'b0, 1'b1, 32'd17, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 2'd3,   1'b0, 1'b1, 32'd17, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 2'd0,   1'b1, 1'b1, 32'd31, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 2'd0,   1'b1, 1'b0, 32'd31, 1'b1);
    tbl[12] = mk(1'b0, 1'b1, SEL_RT, 1'b0, 1'b1, 32'd3,  1'b1);
    tbl[13] = mk(1'b0, 1'b1, SEL_RD, 1'b0, 1'b1, 32'd3,  1'b0);
    tbl[14] = mk(1'b1, 1'b1, SEL_RA, 1'b0, 1'b0, 32'd0,  1'b1);
    tbl[15] = mk(1'b0, 1'b0, 2'd0,   1'b1, 1'b0, 32'd0,  1'b1);

    for (int i = 0; i < 16; i++) begin
      Rst           = tbl[i].rst;
      if4.in_valid  = tbl[i].iv;
      if4.sel       = tbl[i].sel;
      if4.out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 32'(if4.out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_out_data", i),  if4.out_data,        tbl[i].exp_od);
      chk($sformatf("tbl%0d_in_ready", i),  32'(if4.in_ready),  32'(tbl[i].exp_ir));
    end

    // out-of-range select on the 3-input instance
    if4.in_valid = 1'b0;
    if3.in_valid = 1'b1;
    if3.sel = 2'd2;
    tick();
    chk("oor_in2_data", if3.out_data, 32'd7);
    chk("oor_in2_valid", 32'(if3.out_valid), 32'd1);
`ifdef MUX_SEL_CHECK_EN
    chk("oor_in2_err", 32'(if3.sel_err), 32'd0);
`endif
    if3.sel = 2'd3;
    tick();
    chk("oor_sel3_data", if3.out_data, 32'd0);
    chk("oor_sel3_valid", 32'(if3.out_valid), 32'd1);
`ifdef MUX_SEL_CHECK_EN
    chk("oor_sel3_err", 32'(if3.sel_err), 32'd1);
`endif
    if3.sel = 2'd0;
    tick();
    chk("oor_in0_data", if3.out_data, 32'd5);
`ifdef MUX_SEL_CHECK_EN
    chk("oor_in0_err", 32'(if3.sel_err), 32'd0);
`endif
    if3.in_valid = 1'b0;
    tick();
    chk("oor_idle_valid", 32'(if3.out_valid), 32'd0);
`ifdef MUX_SEL_CHECK_EN
    chk("oor_idle_err", 32'(if3.sel_err), 32'd0);
`endif

    // random traffic on the 4-input instance against a 2-deep FIFO model
    q.delete();
    last_out = 32'd0;
    for (int c = 0; c < 10000; c++) begin
      riv   = ($urandom_range(0, 3) != 0);
      rordy = ($urandom_range(0, 3) != 0);
      rsel  = 2'($urandom_range(0, 3));
      rbus  = 20'($urandom);
      if4.in_valid  = riv;
      if4.out_ready = rordy;
      if4.sel       = rsel;
      if4.in_bus    = rbus;
      ev  = (32'(rbus) >> (5 * int'(rsel))) % 32;
      acc = riv && (q.size() < 2);
      drn = (q.size() > 0) && rordy;
      tick();
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ev);
      if (q.size() > 0) last_out = q[0];
      chk("rnd_out_valid", 32'(if4.out_valid), 32'(q.size() > 0));
      chk("rnd_in_ready",  32'(if4.in_ready),  32'(q.size() < 2));
      chk("rnd_out_data",  if4.out_data,       last_out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
